stage3_mac_kernel_acc: RTL and testbench

Parametrised multi-tap multiply-accumulate kernel for the stage-3 convolution path. Each beat carries CI pooled feature values and CI weights. The block multiplies them per channel, reduces them to one beat sum, and accumulates KTAPS beats into one output pixel. It then adds a bias, round-shifts, saturates, optionally applies ReLU, and emits one registered result with a single-cycle valid.

---
 rtl/stage3_mac_kernel_acc.sv | 191 +++++++++++++++++++
 tb/tb_stage3_mac_kernel_acc.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/stage3_mac_kernel_acc.sv
// Multi-tap multiply-accumulate kernel for the stage-3 convolution path.
// Each beat carries CI features and CI weights. The per-channel products are
// reduced to one beat sum, and KTAPS beats are accumulated into one output
// pixel. The pixel is biased, round-shifted, saturated, optionally ReLU'd and
// emitted as a registered result with a one-cycle valid pulse.
// Pipeline: stage 1 registers products, stage 2 accumulates, stage 3 posts.
module stage3_mac_kernel_acc #(
    parameter int CI      = 3,
    parameter int IN_BW   = 8,
    parameter int W_BW    = 8,
    parameter int KTAPS   = 9,
    parameter int BIAS_BW = 16,
    parameter int ACC_BW  = IN_BW + W_BW + $clog2(CI * KTAPS) + 1,
    parameter int SHIFT   = 8,
    parameter int OUT_BW  = 8,
    parameter int RELU_EN = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_clear,
    input  logic                  i_valid,
    input  logic [CI*IN_BW-1:0]   i_data,
    input  logic [CI*W_BW-1:0]    i_weight,
    input  logic [BIAS_BW-1:0]    i_bias,
    output logic                  o_valid,
    output logic [OUT_BW-1:0]     o_data,
    output logic                  o_sat,
    output logic                  o_busy
);

    localparam int P_BW   = IN_BW + W_BW;
    localparam int TAP_BW = (KTAPS > 1) ? $clog2(KTAPS) : 1;
    // Post-processing width: room for acc + bias plus the rounding increment.
    localparam int T_BW   = ((ACC_BW > BIAS_BW) ? ACC_BW : BIAS_BW) + 2;

    localparam logic [TAP_BW-1:0]      LAST_TAP = TAP_BW'(KTAPS - 1);
    // Half an LSB of the shifted result; evaluates to zero when SHIFT is 0.
    localparam logic signed [T_BW-1:0] ROUND    = T_BW'((64'd1 << SHIFT) >> 1);
    localparam logic signed [T_BW-1:0] OUT_MAX  = T_BW'((64'sd1 <<< (OUT_BW - 1)) - 64'sd1);
    localparam logic signed [T_BW-1:0] OUT_MIN  = T_BW'(-(64'sd1 <<< (OUT_BW - 1)));

    // Tap counter
    logic [TAP_BW-1:0] tap_q, tap_d;

    // Stage 1: registered products and window-position flags
    logic signed [P_BW-1:0] prod_q [CI];
    logic signed [P_BW-1:0] prod_d [CI];
    logic                   s1_valid_q, s1_valid_d;
    logic                   s1_first_q, s1_first_d;
    logic                   s1_last_q,  s1_last_d;
    logic [BIAS_BW-1:0]     s1_bias_q,  s1_bias_d;

    // Stage 2: accumulator
    logic signed [ACC_BW-1:0] beat_sum;
    logic signed [ACC_BW-1:0] acc_q, acc_d;
    logic                     s2_valid_q, s2_valid_d;
    logic                     s2_last_q,  s2_last_d;
    logic [BIAS_BW-1:0]       s2_bias_q,  s2_bias_d;

    // Stage 3: registered result
    logic signed [T_BW-1:0] t_sum;
    logic signed [T_BW-1:0] t_shift;
    logic [OUT_BW-1:0]      sat_val;
    logic                   sat_clip;
    logic                   o_valid_q, o_valid_d;
    logic [OUT_BW-1:0]      o_data_q,  o_data_d;
    logic                   o_sat_q,   o_sat_d;

    // Beat acceptance: multiply per channel, tag first/last, advance tap counter
    always_comb begin
        tap_d      = tap_q;
        s1_valid_d = 1'b0;
        s1_first_d = s1_first_q;
        s1_last_d  = s1_last_q;
        s1_bias_d  = s1_bias_q;
        for (int c = 0; c < CI; c++) begin
            prod_d[c] = prod_q[c];
        end
        if (i_clear) begin
            tap_d = '0;
        end else if (i_valid) begin
            s1_valid_d = 1'b1;
            s1_first_d = (tap_q == '0);
            s1_last_d  = (tap_q == LAST_TAP);
            if (tap_q == LAST_TAP) begin
                s1_bias_d = i_bias;
                tap_d     = '0;
            end else begin
                tap_d = tap_q + 1'b1;
            end
            for (int c = 0; c < CI; c++) begin
                prod_d[c] = $signed(i_data[c*IN_BW +: IN_BW]) * $signed(i_weight[c*W_BW +: W_BW]);
            end
        end
    end

    // Adder tree reducing the registered products to one sign-extended beat sum
    always_comb begin
        beat_sum = '0;
        for (int c = 0; c < CI; c++) begin
            beat_sum = beat_sum + ACC_BW'(prod_q[c]);
        end
    end

    // Accumulate: the first beat of a window restarts the sum
    always_comb begin
        acc_d      = acc_q;
        s2_valid_d = 1'b0;
        s2_last_d  = 1'b0;
        s2_bias_d  = s2_bias_q;
        if (i_clear) begin
            acc_d = '0;
        end else if (s1_valid_q) begin
            s2_valid_d = 1'b1;
            s2_last_d  = s1_last_q;
            if (s1_last_q) begin
                s2_bias_d = s1_bias_q;
            end
            acc_d = s1_first_q ? beat_sum : acc_q + beat_sum;
        end
    end

    // Bias, round-half-up shift and saturation of the completed window sum
    always_comb begin
        t_sum    = T_BW'(acc_q) + T_BW'($signed(s2_bias_q));
        t_shift  = (t_sum + ROUND) >>> SHIFT;
        sat_clip = 1'b0;
        sat_val  = t_shift[OUT_BW-1:0];
        if (t_shift > OUT_MAX) begin
            sat_clip = 1'b1;
            sat_val  = OUT_MAX[OUT_BW-1:0];
        end else if (t_shift < OUT_MIN) begin
            sat_clip = 1'b1;
            sat_val  = OUT_MIN[OUT_BW-1:0];
        end
    end

    // Output stage: result and clip flag are held between valid pulses
    always_comb begin
        o_valid_d = s2_last_q & ~i_clear;
        o_data_d  = o_data_q;
        o_sat_d   = o_sat_q;
        if (o_valid_d) begin
            o_sat_d  = sat_clip;
            o_data_d = ((RELU_EN != 0) && t_shift[T_BW-1]) ? '0 : sat_val;
        end
    end

    // State registers for counter, pipeline and output
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tap_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_bias_q  <= '0;
            for (int c = 0; c < CI; c++) begin
                prod_q[c] <= '0;
            end
            acc_q      <= '0;
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_bias_q  <= '0;
            o_valid_q  <= 1'b0;
            o_data_q   <= '0;
            o_sat_q    <= 1'b0;
        end else begin
            tap_q      <= tap_d;
            s1_valid_q <= s1_valid_d;
            s1_first_q <= s1_first_d;
            s1_last_q  <= s1_last_d;
            s1_bias_q  <= s1_bias_d;
            for (int c = 0; c < CI; c++) begin
                prod_q[c] <= prod_d[c];
            end
            acc_q      <= acc_d;
            s2_valid_q <= s2_valid_d;
            s2_last_q  <= s2_last_d;
            s2_bias_q  <= s2_bias_d;
            o_valid_q  <= o_valid_d;
            o_data_q   <= o_data_d;
            o_sat_q    <= o_sat_d;
        end
    end

    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;
    assign o_sat   = o_sat_q;
    assign o_busy  = (tap_q != '0) | s1_valid_q | s2_valid_q | o_valid_q;

endmodule

// File: tb/tb_stage3_mac_kernel_acc.sv
// Directed bench for stage3_mac_kernel_acc: one instance with ReLU off and one
// with ReLU on, sharing the same stimulus, checked against hand-computed values.
module tb_stage3_mac_kernel_acc;

    localparam int CI      = 3;
    localparam int IN_BW   = 8;
    localparam int W_BW    = 8;
    localparam int KTAPS   = 9;
    localparam int BIAS_BW = 16;
    localparam int OUT_BW  = 8;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                i_clear = 1'b0;
    logic                i_valid = 1'b0;
    logic [CI*IN_BW-1:0] i_data = '0;
    logic [CI*W_BW-1:0]  i_weight = '0;
    logic [BIAS_BW-1:0]  i_bias = '0;
    logic                o_valid, r_valid;
    logic [OUT_BW-1:0]   o_data, r_data;
    logic                o_sat, r_sat;
    logic                o_busy, r_busy;

    int vec_count = 0;
    int err_count = 0;
    int cycle_count = 0;

    int res_data[$];
    int res_sat[$];
    int res_relu[$];
    int res_cycle[$];
    int last_q[$];

    stage3_mac_kernel_acc dut (
        .clk(clk), .reset_n(reset_n), .i_clear(i_clear), .i_valid(i_valid),
        .i_data(i_data), .i_weight(i_weight), .i_bias(i_bias),
        .o_valid(o_valid), .o_data(o_data), .o_sat(o_sat), .o_busy(o_busy)
    );

    stage3_mac_kernel_acc #(.RELU_EN(1)) dut_relu (
        .clk(clk), .reset_n(reset_n), .i_clear(i_clear), .i_valid(i_valid),
        .i_data(i_data), .i_weight(i_weight), .i_bias(i_bias),
        .o_valid(r_valid), .o_data(r_data), .o_sat(r_sat), .o_busy(r_busy)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Cycle counter: value during a cycle is the index of that cycle
    always @(posedge clk) cycle_count++;

    // Capture every result pulse mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (o_valid) begin
            res_data.push_back(int'($signed(o_data)));
            res_sat.push_back(int'(o_sat));
            res_relu.push_back(r_valid ? int'($signed(r_data)) : 999);
            res_cycle.push_back(cycle_count);
        end
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vec_count++;
        if (observed !== expected) begin
            err_count++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive n_beats beats of uniform data/weight/bias, with up to max_idle idle
    // cycles after each beat; i_valid is left high after the final beat.
    task automatic applyStimulus(input int d_in, input int w_in, input int b_in,
                                 input int n_beats, input int max_idle);
        logic [IN_BW-1:0] d_v;
        logic [W_BW-1:0]  w_v;
        int               idle;
        d_v = d_in[IN_BW-1:0];
        w_v = w_in[W_BW-1:0];
        for (int i = 0; i < n_beats; i++) begin
            @(negedge clk);
            i_valid  = 1'b1;
            i_data   = {CI{d_v}};
            i_weight = {CI{w_v}};
            i_bias   = b_in[BIAS_BW-1:0];
            @(posedge clk);
            #1;
            if ((i % KTAPS) == KTAPS - 1) last_q.push_back(cycle_count - 1);
            if (max_idle > 0) begin
                idle = $urandom_range(max_idle, 0);
                repeat (idle) begin
                    @(negedge clk);
                    i_valid = 1'b0;
                end
            end
        end
    endtask

    task automatic goIdle(input int n);
        repeat (n) begin
            @(negedge clk);
            i_valid = 1'b0;
        end
    endtask

    // Wait (bounded) for the next captured result and check it and its latency
    task automatic waitResult(input string tag, input int exp_data, input int exp_sat,
                              input int exp_relu);
        int waited = 0;
        int lat_ref;
        while (res_data.size() == 0 && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (res_data.size() == 0) begin
            checkOutput({tag, "_timeout"}, res_data.size(), 1);
            return;
        end
        checkOutput({tag, "_data"}, res_data.pop_front(), exp_data);
        checkOutput({tag, "_sat"},  res_sat.pop_front(),  exp_sat);
        checkOutput({tag, "_relu"}, res_relu.pop_front(), exp_relu);
        lat_ref = (last_q.size() > 0) ? last_q.pop_front() : -100;
        checkOutput({tag, "_latency"}, res_cycle.pop_front() - lat_ref, 3);
    endtask

    initial begin
        int waited;

        // Reset state
        #1;
        checkOutput("rst_valid", int'(o_valid), 0);
        checkOutput("rst_data",  int'(o_data),  0);
        checkOutput("rst_sat",   int'(o_sat),   0);
        checkOutput("rst_busy",  int'(o_busy),  0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Basic window with busy behaviour around the result pulse
        applyStimulus(16, 16, 0, KTAPS, 0);
        goIdle(1);
        waited = 0;
        while (!o_valid && waited < 10) begin
            @(posedge clk);
            #1;
            waited++;
        end
        checkOutput("busy_at_valid", int'(o_busy), 1);
        @(posedge clk);
        #1;
        checkOutput("busy_after_valid", int'(o_busy), 0);
        waitResult("pos16", 27, 0, 27);

        // Negative window: ReLU instance clamps to zero
        applyStimulus(-16, 16, 0, KTAPS, 0);
        goIdle(1);
        waitResult("neg16", -27, 0, 0);

        // Saturation in both directions
        applyStimulus(127, 127, 0, KTAPS, 0);
        goIdle(1);
        waitResult("sat_pos", 127, 1, 127);
        applyStimulus(127, -127, 0, KTAPS, 0);
        goIdle(1);
        waitResult("sat_neg", -128, 1, 0);

        // Rounding boundary through the bias path
        applyStimulus(0, 16, 128, KTAPS, 0);
        goIdle(1);
        waitResult("round_up", 1, 0, 1);
        applyStimulus(0, 16, 127, KTAPS, 0);
        goIdle(1);
        waitResult("round_dn", 0, 0, 0);

        // Random idle gaps, then two windows back to back
        applyStimulus(16, 16, 0, KTAPS, 3);
        goIdle(1);
        waitResult("gappy", 27, 0, 27);
        applyStimulus(16, 16, 0, 2 * KTAPS, 0);
        goIdle(1);
        waitResult("b2b_first", 27, 0, 27);
        waitResult("b2b_second", 27, 0, 27);
        goIdle(4);
        checkOutput("b2b_extra_valid", res_data.size(), 0);

        // Clear together with a valid beat after four beats
        applyStimulus(5, 7, 300, 4, 0);
        @(negedge clk);
        i_valid = 1'b1;
        i_clear = 1'b1;
        @(negedge clk);
        i_clear = 1'b0;
        i_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("clr_busy", int'(o_busy), 0);
        checkOutput("clr_hold_data", int'($signed(o_data)), 27);
        checkOutput("clr_hold_sat", int'(o_sat), 0);

        // Clear alone after four beats
        applyStimulus(5, 7, 300, 4, 0);
        @(negedge clk);
        i_valid = 1'b0;
        i_clear = 1'b1;
        @(negedge clk);
        i_clear = 1'b0;
        goIdle(8);
        checkOutput("clr_no_valid", res_data.size(), 0);

        // A full window after the aborts starts cleanly
        applyStimulus(16, 16, 0, KTAPS, 0);
        goIdle(1);
        waitResult("post_clear", 27, 0, 27);
        goIdle(6);
        checkOutput("final_extra_valid", res_data.size(), 0);
        checkOutput("final_busy", int'(o_busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
